// File: rtl/two_way_grant_scheduler.sv
// two_way_grant_scheduler: arbitrates two level requests and drives the
// sel/Enable pair of a 1-to-2 decoder with a bounded grant and a dead gap.
// Ports: clk, rst (async, active-high), req[1:0], early_rel -> sel,
//   Enable, busy (GRANT or GAP), grant_cnt[7:0] (saturating grant count).
// Macro GRANT_FIXED_PRIORITY_EN: channel 0 always wins a tie instead of
//   round-robin; the pointer is then held at 0.
module two_way_grant_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       early_rel,
  output logic       sel,
  output logic       Enable,
  output logic       busy,
  output logic [7:0] grant_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             ptr;
  logic             ptr_n;
  logic             sel_n;
  logic             en_n;
  logic             busy_n;
  logic [7:0]       gcnt_n;
  logic             winner;

  // A lone requester always wins; a tie goes to the pointer (or to
  // channel 0 in fixed-priority builds).
`ifdef GRANT_FIXED_PRIORITY_EN
  assign winner = ~req[0];
`else
  assign winner = (req == 2'b11) ? ptr : req[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      sel       <= 1'b0;
      Enable    <= 1'b0;
      busy      <= 1'b0;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      Enable    <= en_n;
      busy      <= busy_n;
      grant_cnt <= gcnt_n;
    end
  end

  // sel is only ever loaded together with the IDLE->GRANT transition,
  // so it is stable for the whole time Enable is high.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    sel_n   = sel;
    en_n    = Enable;
    busy_n  = busy;
    gcnt_n  = grant_cnt;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_n = GRANT;
          sel_n   = winner;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = HOLD_LD;
`ifdef GRANT_FIXED_PRIORITY_EN
          ptr_n   = 1'b0;
`else
          ptr_n   = ~winner;
`endif
          if (grant_cnt != 8'hff)
            gcnt_n = grant_cnt + 8'd1;
        end
      end
      GRANT: begin
        if (cnt == '0 || early_rel) begin
          en_n = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LD;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        en_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_two_way_grant_scheduler.sv
// tb_two_way_grant_scheduler: directed stimulus with a grant scoreboard
// (sel, Enable length, grant_cnt, preceding Enable-low run per grant).
module tb_two_way_grant_scheduler;

  typedef struct {
    int gsel;
    int len;
    int gcnt;
    int gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       early_rel;
  logic       sel;
  logic       Enable;
  logic       busy;
  logic [7:0] grant_cnt;

  logic [1:0] req1;
  logic       rel1;
  logic       sel1;
  logic       en1;
  logic       busy1;
  logic [7:0] gcnt1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  two_way_grant_scheduler dut (
    .clk(clk), .rst(rst), .req(req),
    .early_rel(early_rel), .sel(sel),
    .Enable(Enable), .busy(busy),
    .grant_cnt(grant_cnt)
  );

  two_way_grant_scheduler #(
    .HOLD_CYCLES(1), .GAP_CYCLES(0)
  ) u1 (
    .clk(clk), .rst(rst), .req(req1),
    .early_rel(rel1), .sel(sel1),
    .Enable(en1), .busy(busy1),
    .grant_cnt(gcnt1)
  );

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr(int k);
`ifdef GRANT_FIXED_PRIORITY_EN
    return 0;
`else
    return k % 2;
`endif
  endfunction

  // Monitor: measures each Enable-high run and checks it against the
  // oldest expected grant.
  bit in_grant = 0;
  int cur_len = 0;
  int cur_sel = 0;
  int cur_cnt = 0;
  int cur_gap = 0;
  int low_run = 0;

  always @(negedge clk) begin
    if (in_grant && (!Enable || rst)) begin
      in_grant = 0;
      if (q.size() == 0) begin
        chk("unexpected_grant", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grant_sel", cur_sel, e.gsel);
        chk("grant_len", cur_len, e.len);
        chk("grant_cnt", cur_cnt, e.gcnt);
        if (e.gap >= 0)
          chk("enable_low_gap", cur_gap, e.gap);
      end
      low_run = 0;
    end
    if (rst) begin
      low_run = 0;
    end else if (Enable && !in_grant) begin
      in_grant = 1;
      cur_len  = 1;
      cur_sel  = int'(sel);
      cur_cnt  = int'(grant_cnt);
      cur_gap  = low_run;
    end else if (Enable) begin
      cur_len++;
      chk("sel_stable", int'(sel), cur_sel);
    end else begin
      low_run++;
    end
  end

  task automatic push(int s, int l, int c, int g);
    exp_t e;
    e.gsel = s;
    e.len  = l;
    e.gcnt = c;
    e.gap  = g;
    q.push_back(e);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_enable"}, int'(Enable), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_gcnt"}, int'(grant_cnt), 0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; req = 0; early_rel = 0;
    req1 = 0; rel1 = 0;
    #1 rst = 1;
    #1 chk_zero("reset");
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    chk_zero("post_reset");

    // single request on channel 1
    req = 2'b10;
    push(1, 4, 1, -1);
    @(posedge clk); #1 req = 0;
    repeat (5) @(negedge clk);
    chk("gap_busy", int'(busy), 1);
    chk("gap_enable", int'(Enable), 0);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("single_gcnt", int'(grant_cnt), 1);

    // tie held: pointer is 0 after the channel-1 grant
    req = 2'b11;
    push(rr(0), 4, 2, -1);
    push(rr(1), 4, 3, 2);
    push(rr(2), 4, 4, 2);
    push(rr(3), 4, 5, 2);
    repeat (20) @(posedge clk);
    #1 req = 0;
    repeat (10) @(negedge clk);

    // early release in the 2nd Enable-high cycle
    req = 2'b01;
    push(0, 2, 6, -1);
    @(posedge clk); #1 req = 0;
    @(posedge clk); #1 early_rel = 1;
    @(posedge clk); #1 early_rel = 0;
    repeat (3) @(negedge clk);

    // early_rel in IDLE: no grant, and no shortening of the next one
    early_rel = 1;
    @(posedge clk); #1 early_rel = 0;
    @(negedge clk);
    chk("idle_rel_busy", int'(busy), 0);
    chk("idle_rel_enable", int'(Enable), 0);
    early_rel = 1; req = 2'b01;
    push(0, 4, 7, -1);
    @(posedge clk); #1 begin early_rel = 0; req = 0; end
    repeat (8) @(negedge clk);

    // async reset in grant cycle 3 (Enable seen high on 2 negedges)
    req = 2'b01;
    push(0, 2, 8, -1);
    @(posedge clk); #1 req = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1 chk_zero("async_rst");
    @(negedge clk) begin rst = 0; req = 2'b11; end
    push(0, 4, 1, -1);
    @(posedge clk); #1 req = 0;
    repeat (8) @(negedge clk);

    // HOLD=1, GAP=0: 1-high/1-low pulses, early_rel has no extra effect
    req1 = 2'b11; rel1 = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pulse_enable", int'(en1), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0)
        chk("pulse_sel", int'(sel1), rr(i / 2));
    end
    repeat (600) @(negedge clk);
    chk("gcnt_saturate", int'(gcnt1), 255);
    req1 = 0; rel1 = 0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/two_way_grant_scheduler.md
Name: two_way_grant_scheduler

Overview:
- Upstream stage that drives the select/enable pair of the team's 1-to-2 decoder (OneToTwoDecoder).
- Arbitrates two level-sensitive request lines.
- Drives the selected channel on sel with Enable high for a bounded number of cycles, then enforces a dead gap.
- Guarantees sel is stable whenever Enable is high, so the decoder outputs never glitch between channels.

Parameters:
- HOLD_CYCLES, 4, number of cycles Enable stays high per grant; legal range 1..2^CNT_W.
- GAP_CYCLES, 1, extra dead cycles after a grant before re-arbitration; legal range 0..2^CNT_W-1.
- CNT_W, 4, width of the internal hold/gap down-counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  2  per-channel request, level-sensitive; bit i requests channel i
- early_rel  input  1  terminates the current grant early; only sampled in GRANT
- sel  output  1  channel index to the decoder input
- Enable  output  1  decoder enable
- busy  output  1  high in GRANT and GAP
- grant_cnt  output  8  count of grants issued, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, Enable=0, busy=0, grant_cnt=0, round-robin pointer=0 (channel 0 preferred). Outputs clear immediately, without waiting for a clock edge.
- All outputs are registered. The states are IDLE, GRANT and GAP.
- IDLE:
  - At each posedge, if req!=0, pick a winner: the single requester, or the pointer value if req=2'b11.
  - Next cycle: state=GRANT, sel=winner, Enable=1, busy=1, counter=HOLD_CYCLES-1, pointer=~winner.
  - grant_cnt increments by 1, saturating at 255.
  - If req=0, stay in IDLE with outputs unchanged (Enable=0, busy=0, sel holds its last value).
- GRANT:
  - Enable=1. The counter decrements each cycle.
  - When the counter reaches 0, or early_rel=1 is sampled, the next state is GAP if GAP_CYCLES>0, else IDLE. Enable=0 from that next cycle.
  - Without early release, Enable stays high exactly HOLD_CYCLES cycles.
  - With early_rel in grant cycle k, Enable is high k cycles.
  - req changes during GRANT are ignored. Dropping req does not end the grant.
- GAP:
  - Enable=0, busy=1, sel holds. Lasts GAP_CYCLES cycles, then IDLE with busy=0.
- Timing rules:
  - Latency from req asserted (sampled) to Enable=1 is 1 cycle.
  - Minimum Enable-low time between back-to-back grants is GAP_CYCLES+1 cycles (the IDLE arbitration cycle is always spent).
  - sel changes only on entry to GRANT. Enable never rises in the same cycle sel changes from a stale value to a new one during an active grant.
- Boundary conditions:
  - HOLD_CYCLES=1 gives a one-cycle Enable pulse; early_rel in that cycle has no further effect.
  - early_rel outside GRANT is ignored.
  - rst mid-GRANT or mid-GAP aborts immediately. grant_cnt is lost and the pointer returns to 0.
  - At grant_cnt=255, further grants leave it at 255.

Optional Feature:
- Macro: GRANT_FIXED_PRIORITY_EN.
- Defined: on req=2'b11 channel 0 always wins. The pointer is not used and is held at 0.
- Undefined (default): round-robin as above. Continuous req=2'b11 alternates channels.

Test Plan:
- Reset: rst=1 mid-simulation with arbitrary state -> same delta: Enable=0, sel=0, busy=0, grant_cnt=0. Release rst with req=0 -> outputs remain 0.
- Single request, defaults (HOLD=4, GAP=1): req=2'b10 for one cycle -> next cycle sel=1, Enable=1 for exactly 4 cycles, then 1 cycle busy=1 with Enable=0, then busy=0; grant_cnt=1.
- Round-robin: req=2'b11 held for 20 cycles -> grants on sel=0,1,0,1 in order, each with Enable high 4 cycles, and Enable low exactly 2 cycles between grants; grant_cnt=4 after the 4th grant.
- Early release: req=2'b01, early_rel=1 in the 2nd Enable-high cycle -> Enable high for 2 cycles only, then GAP; early_rel pulsed in IDLE -> no effect.
- Async reset mid-grant: rst asserted between clock edges in grant cycle 3 -> Enable=0 before the next edge. After release with req=2'b11 -> sel=0 wins (pointer reset).
- GRANT_FIXED_PRIORITY_EN defined: req=2'b11 held for 20 cycles -> every grant has sel=0. Also check HOLD_CYCLES=1, GAP_CYCLES=0 -> Enable pulses 1 cycle high, 1 cycle low, repeating.
